// File: rtl/control_pkg.sv
// Purpose: shared opcodes, control-word layout, FSM states and opcode-class helpers.
// Latency: n/a (types and functions only).
// Backpressure: n/a.
package control_pkg;

  localparam int FIELD_W = 5;

  localparam logic [FIELD_W-1:0] OP_NOP  = 5'b00000;
  localparam logic [FIELD_W-1:0] OP_STR  = 5'b00001;
  localparam logic [FIELD_W-1:0] OP_LDR  = 5'b00010;
  localparam logic [FIELD_W-1:0] OP_BNE  = 5'b00011;
  localparam logic [FIELD_W-1:0] OP_ADD1 = 5'b00100;
  localparam logic [FIELD_W-1:0] OP_VSTR = 5'b10001;
  localparam logic [FIELD_W-1:0] OP_VLDR = 5'b10010;
  localparam logic [FIELD_W-1:0] OP_ARK  = 5'b10011;
  localparam logic [FIELD_W-1:0] OP_SHR  = 5'b10100;
  localparam logic [FIELD_W-1:0] OP_MIXC = 5'b10101;
  localparam logic [FIELD_W-1:0] OP_ROTW = 5'b10110;
  localparam logic [FIELD_W-1:0] OP_RCON = 5'b10111;

  // MSB-first layout of the control word; alu fields are resized at the top level.
  typedef struct packed {
    logic               rsvd;
    logic               load;
    logic               wre;
    logic               vector_wre;
    logic               wme_a;
    logic               wme_b;
    logic [1:0]         wb_mux;
    logic [1:0]         vwb_mux;
    logic [FIELD_W-1:0] alu_op;
    logic [FIELD_W-1:0] alu_vector_op;
  } ctrl_word_t;

  typedef enum logic [1:0] {IDLE, LOAD_WAIT, VEC_WAIT} ctrl_state_t;

  // Multi-cycle AES ops that occupy the vector unit.
  function automatic logic is_aes_op(input logic [FIELD_W-1:0] op);
    return (op >= OP_ARK) && (op <= OP_RCON);
  endfunction

  // Loads that need nop bubbles behind them.
  function automatic logic is_load_op(input logic [FIELD_W-1:0] op);
    return (op == OP_LDR) || (op == OP_VLDR);
  endfunction

endpackage

// File: rtl/opcode_decoder.sv
// Purpose: combinational opcode -> control word, illegal flag and op class.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; caller decides when the result is consumed.
module opcode_decoder
  import control_pkg::*;
#(
  parameter int OPCODE_W = 5
) (
  input  logic [OPCODE_W-1:0] opcode,
  output ctrl_word_t          word,
  output logic                illegal,
  output logic                load_op,
  output logic                aes_op
);

  // Opcodes wider than the table are legal only when the extra bits are zero.
  localparam int PAD_W = (OPCODE_W > FIELD_W) ? OPCODE_W : FIELD_W;

  logic [PAD_W-1:0]   op_ext;
  logic [FIELD_W-1:0] op5;
  logic               high_clear;

  assign op_ext     = PAD_W'(opcode);
  assign op5        = op_ext[FIELD_W-1:0];
  assign high_clear = ((op_ext >> FIELD_W) == '0);
  assign load_op    = high_clear && is_load_op(op5);
  assign aes_op     = high_clear && is_aes_op(op5);

  // Field table; unknown opcodes fall back to an all-zero (nop) word.
  always_comb begin
    word    = '0;
    illegal = 1'b0;
    if (!high_clear) begin
      illegal = 1'b1;
    end else begin
      case (op5)
        OP_NOP: ;
        OP_STR: begin
          word.wme_a  = 1'b1;
          word.alu_op = OP_STR;
        end
        OP_LDR: begin
          word.load   = 1'b1;
          word.wre    = 1'b1;
          word.alu_op = OP_LDR;
        end
        OP_BNE: word.alu_op = OP_BNE;
        OP_ADD1: begin
          word.wre    = 1'b1;
          word.wb_mux = 2'b01;
          word.alu_op = OP_ADD1;
        end
        OP_VSTR: begin
          word.wme_b         = 1'b1;
          word.alu_vector_op = OP_VSTR;
        end
        OP_VLDR: begin
          word.vector_wre    = 1'b1;
          word.alu_vector_op = OP_VLDR;
        end
        OP_ARK, OP_SHR, OP_MIXC, OP_ROTW, OP_RCON: begin
          word.vector_wre    = 1'b1;
          word.vwb_mux       = 2'b01;
          word.alu_vector_op = op5;
        end
        default: illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/pipelined_control_unit.sv
// Purpose: registered opcode decode with load bubbles and vector-unit occupancy hold.
// Latency: 1 cycle from accept to control_signals.
// Backpressure: issue_ready low while stalled, in load bubbles, or while the vector unit is busy.
module pipelined_control_unit
  import control_pkg::*;
#(
  parameter  int OPCODE_W     = 5,
  parameter  int ALU_OP_W     = 5,
  parameter  int VEC_LAT      = 4,
  parameter  int LOAD_BUBBLES = 1,
  localparam int CTRL_W       = 10 + 2*ALU_OP_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [OPCODE_W-1:0] opCode,
  input  logic                instr_valid,
  output logic                issue_ready,
  input  logic                stall,
  input  logic                flush,
  output logic [CTRL_W-1:0]   control_signals,
  output logic                ctrl_valid,
  output logic                vec_busy,
  output logic                illegal_op
);

  localparam logic [3:0] LB_CNT  = 4'(LOAD_BUBBLES);
  localparam logic [3:0] VEC_CNT = 4'(VEC_LAT - 1);

  ctrl_state_t       state;
  logic [3:0]        cnt;
  ctrl_word_t        dec_word;
  logic              dec_illegal;
  logic              dec_load;
  logic              dec_aes;
  logic [CTRL_W-1:0] dec_flat;

  opcode_decoder #(.OPCODE_W(OPCODE_W)) u_dec (
    .opcode  (opCode),
    .word    (dec_word),
    .illegal (dec_illegal),
    .load_op (dec_load),
    .aes_op  (dec_aes)
  );

  assign dec_flat = {dec_word.rsvd, dec_word.load, dec_word.wre, dec_word.vector_wre,
                     dec_word.wme_a, dec_word.wme_b, dec_word.wb_mux, dec_word.vwb_mux,
                     ALU_OP_W'(dec_word.alu_op), ALU_OP_W'(dec_word.alu_vector_op)};

  // Only IDLE accepts; flush does not gate ready, it just blocks the accept.
  assign issue_ready = (state == IDLE) && !stall;

  // Issue FSM. VEC_WAIT covers the AES output cycle plus VEC_LAT-1 nop cycles,
  // so vec_busy stays high for VEC_LAT cycles in total.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      cnt             <= '0;
      control_signals <= '0;
      ctrl_valid      <= 1'b0;
      vec_busy        <= 1'b0;
      illegal_op      <= 1'b0;
    end else if (flush) begin
      state           <= IDLE;
      cnt             <= '0;
      control_signals <= '0;
      ctrl_valid      <= 1'b0;
      vec_busy        <= 1'b0;
      illegal_op      <= 1'b0;
    end else if (stall) begin
      illegal_op <= 1'b0;
    end else begin
      control_signals <= '0;
      ctrl_valid      <= 1'b0;
      vec_busy        <= 1'b0;
      illegal_op      <= 1'b0;
      case (state)
        IDLE: begin
          if (instr_valid) begin
            control_signals <= dec_flat;
            ctrl_valid      <= !dec_illegal;
            illegal_op      <= dec_illegal;
            if (dec_load && (LOAD_BUBBLES > 0)) begin
              state <= LOAD_WAIT;
              cnt   <= LB_CNT;
            end
            if (dec_aes) begin
              vec_busy <= 1'b1;
              if (VEC_LAT > 1) begin
                state <= VEC_WAIT;
                cnt   <= VEC_CNT;
              end
            end
          end
        end
        LOAD_WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= IDLE;
        end
        VEC_WAIT: begin
          if (cnt == 4'd0) begin
            state <= IDLE;
          end else begin
            cnt      <= cnt - 4'd1;
            vec_busy <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Purpose: scoreboard bench for pipelined_control_unit against a transaction-level model.
// Latency: expected response per cycle is compared one cycle after the inputs.
// Backpressure: issue_ready is predicted from the model's blocked-cycle count.
module tb_pipelined_control_unit;

  localparam int VEC_LAT = 4;
  localparam int LB      = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        instr_valid = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic [4:0]  opCode = 5'd0;
  logic        issue_ready;
  logic [19:0] control_signals;
  logic        ctrl_valid;
  logic        vec_busy;
  logic        illegal_op;

  always #5 clk = ~clk;

  pipelined_control_unit #(
    .OPCODE_W(5), .ALU_OP_W(5), .VEC_LAT(VEC_LAT), .LOAD_BUBBLES(LB)
  ) dut (
    .clk(clk), .rst(rst), .opCode(opCode), .instr_valid(instr_valid),
    .issue_ready(issue_ready), .stall(stall), .flush(flush),
    .control_signals(control_signals), .ctrl_valid(ctrl_valid),
    .vec_busy(vec_busy), .illegal_op(illegal_op)
  );

  typedef struct {
    logic [19:0] w;
    logic        v;
    logic        b;
    logic        i;
    time         t;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passes = 0;

  // Model state: last word/valid, cycles issue stays blocked, cycles vec unit stays busy.
  logic [19:0] m_word  = '0;
  logic        m_valid = 1'b0;
  logic        m_ill   = 1'b0;
  int          m_block = 0;
  int          m_busy  = 0;

  // Reference table {legal, word}, written straight from the field list.
  function automatic logic [20:0] ref_decode(input logic [4:0] op);
    case (op)
      5'd0:  return {1'b1, 20'h00000};
      5'd1:  return {1'b1, 20'h08020};
      5'd2:  return {1'b1, 20'h60040};
      5'd3:  return {1'b1, 20'h00060};
      5'd4:  return {1'b1, 20'h21080};
      5'd17: return {1'b1, 20'h04011};
      5'd18: return {1'b1, 20'h10012};
      5'd19, 5'd20, 5'd21, 5'd22, 5'd23: return {1'b1, 20'h10400 | {15'd0, op}};
      default: return {1'b0, 20'h00000};
    endcase
  endfunction

  // One clock of stimulus: drive, check ready, advance model, push expectation.
  task automatic cycle(input logic r, input logic v, input logic [4:0] op,
                       input logic s, input logic f);
    logic [20:0] d;
    logic        rdy_exp;
    logic        acc;
    exp_t        e;
    @(posedge clk);
    #1;
    rst = r; instr_valid = v; opCode = op; stall = s; flush = f;
    #1;
    rdy_exp = (m_block == 0) && !s;
    if (!r) begin
      checks++;
      if (issue_ready === rdy_exp) passes++;
      else $display("FAIL issue_ready at %0t: got %b want %b", $time, issue_ready, rdy_exp);
    end
    if (r || f) begin
      m_word = '0; m_valid = 1'b0; m_ill = 1'b0; m_block = 0; m_busy = 0;
    end else if (s) begin
      m_ill = 1'b0;
    end else begin
      acc = v && (m_block == 0);
      if (m_block > 0) m_block--;
      if (m_busy > 0) m_busy--;
      m_word = '0; m_valid = 1'b0; m_ill = 1'b0;
      if (acc) begin
        d       = ref_decode(op);
        m_word  = d[19:0];
        m_valid = d[20];
        m_ill   = !d[20];
        if ((op == 5'd2 || op == 5'd18) && LB > 0) m_block = LB;
        if (op >= 5'd19 && op <= 5'd23) begin
          m_busy = VEC_LAT;
          if (VEC_LAT > 1) m_block = VEC_LAT;
        end
      end
    end
    e.w = m_word; e.v = m_valid; e.b = (m_busy > 0); e.i = m_ill; e.t = $time;
    exp_q.push_back(e);
  endtask

  task automatic offer(input logic [4:0] op);
    cycle(1'b0, 1'b1, op, 1'b0, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  // Monitor: compare the entry whose inputs were applied before the last edge.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0 && ($time - exp_q[0].t) > 5) begin
        e = exp_q.pop_front();
        checks++;
        if ({control_signals, ctrl_valid, vec_busy, illegal_op} === {e.w, e.v, e.b, e.i})
          passes++;
        else
          $display("FAIL outputs at %0t: got ctrl=%h v=%b busy=%b ill=%b want ctrl=%h v=%b busy=%b ill=%b",
                   $time, control_signals, ctrl_valid, vec_busy, illegal_op, e.w, e.v, e.b, e.i);
      end
    end
  end

  initial begin : stim
    logic [4:0] legal [12];
    logic [4:0] op;
    int         wait_cnt;
    legal = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd17, 5'd18, 5'd19, 5'd20, 5'd21, 5'd22, 5'd23};

    cycle(1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
    idle(1);

    // Back-to-back scalar ops.
    offer(5'd1); offer(5'd4); offer(5'd3); idle(2);

    // Load followed by add_1 offered immediately and held until taken.
    offer(5'd2); offer(5'd4); offer(5'd4); idle(2);

    // AddRoundKey occupancy window.
    offer(5'd19); idle(6);

    // Stall for two cycles inside the vector window.
    offer(5'd19); idle(1);
    cycle(1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
    idle(6);

    // Flush during the load bubble while ldr is offered, then a fresh issue.
    offer(5'd2);
    cycle(1'b0, 1'b1, 5'd2, 1'b0, 1'b1);
    offer(5'd4); idle(2);

    // Unknown opcode, then vector store/load.
    offer(5'd15); idle(2);
    offer(5'd17); offer(5'd18); idle(2);

    // Reset in the middle of the vector window.
    offer(5'd20); idle(1);
    cycle(1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
    idle(3);

    // Randomised traffic.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 1) == 0) op = legal[$urandom_range(0, 11)];
      else op = 5'($urandom_range(0, 31));
      cycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0), op,
            ($urandom_range(0, 7) == 0), ($urandom_range(0, 19) == 0));
    end
    idle(2);

    wait_cnt = 0;
    while (exp_q.size() > 0 && wait_cnt < 20) begin
      @(negedge clk);
      wait_cnt++;
    end
    if (exp_q.size() > 0) begin
      checks++;
      $display("FAIL drain: got %0d pending entries want 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/pipelined_control_unit.md
Name: pipelined_control_unit

Overview:
Parametrised, registered successor to the combinational opcode decoder. It decodes scalar and vector (AES) opcodes into the packed control word and issues one instruction per cycle through a valid/ready handshake. It inserts nop bubbles after loads and holds issue while multi-cycle vector AES operations occupy the vector unit. It sits between instruction fetch/decode and the ID/EX pipeline register, and honours stall and flush requests from the hazard unit.

Parameters:
OPCODE_W, 5, opcode width
ALU_OP_W, 5, width of the aluOp and aluVectorOp fields; control word width CTRL_W = 10 + 2*ALU_OP_W
VEC_LAT, 4, cycles a vector AES op (10011..10111) occupies the vector unit; legal range 1..15
LOAD_BUBBLES, 1, nop cycles inserted after ldr/vldr; legal range 0..3

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
opCode  in  OPCODE_W  opcode offered for issue
instr_valid  in  1  opCode is valid
issue_ready  out  1  block accepts opCode this cycle
stall  in  1  hazard-unit hold request
flush  in  1  kill the in-flight/pending issue
control_signals  out  CTRL_W  registered control word
ctrl_valid  out  1  control_signals holds a real (non-bubble) instruction
vec_busy  out  1  vector unit occupied
illegal_op  out  1  one-cycle pulse: an unknown opcode was accepted

Behaviour:
- One clock; reset is synchronous and active-high (clk, rst).
- Control word is packed MSB to LSB: {1'b0, load, wre, vector_wre, wme_a, wme_b, wb_mux[1:0], vwb_mux[1:0], aluOp, aluVectorOp}.
- Field values per opcode:
  - nop 00000: all zero.
  - str 00001: wme_a=1, aluOp=00001.
  - ldr 00010: load=1, wre=1, aluOp=00010.
  - bne 00011: aluOp=00011.
  - add_1 00100: wre=1, wb_mux=01, aluOp=00100.
  - vstr 10001: wme_b=1, aluVectorOp=10001.
  - vldr 10010: vector_wre=1, aluVectorOp=10010.
  - AES ops 10011..10111: vector_wre=1, vwb_mux=01, aluVectorOp=opcode.
  - Any other opcode: decodes as nop, ctrl_valid=0, illegal_op=1 for one cycle.
- Reset values: control_signals=0, ctrl_valid=0, vec_busy=0, illegal_op=0, FSM=IDLE, counters=0. issue_ready is combinational and equals 1 in IDLE once out of reset.
- Accept condition: instr_valid && issue_ready && !stall. Decoded word appears on control_signals the next cycle (latency 1). Without an accept, control_signals is 0 and ctrl_valid is 0.
- FSM states:
  - IDLE: issue_ready = !stall. On accepting ldr/vldr with LOAD_BUBBLES>0, go to LOAD_WAIT with cnt=LOAD_BUBBLES. On accepting an AES op with VEC_LAT>1, go to VEC_WAIT with cnt=VEC_LAT-1. Otherwise stay in IDLE.
  - LOAD_WAIT: issue_ready=0; emit a nop each cycle; cnt decrements; return to IDLE on the cycle cnt reaches 0 (exactly LOAD_BUBBLES nops).
  - VEC_WAIT: issue_ready=0; vec_busy=1; emit a nop each cycle; cnt decrements; return to IDLE after exactly VEC_LAT-1 cycles. vec_busy is also 1 in the cycle the AES word is on the output.
- stall=1: control_signals, ctrl_valid, FSM state and cnt all hold. Nothing is accepted.
- flush=1 (priority over stall and accept): next cycle control_signals=0 and ctrl_valid=0; FSM goes to IDLE and cnt=0; the offered opcode is not accepted. vec_busy clears.
- rst has priority over flush.
- Counter width: 4 bits; no wrap, since parameter ranges are bounded.

Decomposition:
- Package control_pkg holds:
  - opcode localparams (OP_NOP, OP_STR, OP_LDR, OP_BNE, OP_ADD1, OP_VSTR, OP_VLDR, OP_ARK, OP_SHR, OP_MIXC, OP_ROTW, OP_RCON);
  - a packed struct ctrl_word_t;
  - FSM enum ctrl_state_t {IDLE, LOAD_WAIT, VEC_WAIT};
  - helper function is_aes_op().
- Sub-module opcode_decoder: combinational opcode -> ctrl_word_t plus an illegal flag. The top level holds the FSM, counter and output registers.

Test Plan:
- Reset, then issue str, add_1, bne back-to-back -> outputs 20'h08020, 20'h21080, 20'h00060 on consecutive cycles; issue_ready stays 1 throughout.
- ldr with LOAD_BUBBLES=1, then add_1 offered immediately -> 20'h60040, then one cycle 20'h00000 with ctrl_valid=0 and issue_ready=0, then 20'h21080.
- AddRoundKey with VEC_LAT=4 -> 20'h10413 with vec_busy=1, then 3 nop cycles with vec_busy=1, then issue_ready=1 on the next cycle.
- stall held 2 cycles mid-VEC_WAIT -> control_signals and cnt frozen; total busy window becomes 6 cycles.
- flush during LOAD_WAIT while ldr is offered -> next cycle output 0, FSM IDLE, issue_ready=1, opcode not accepted.
- opcode 01111 accepted -> output 0, ctrl_valid=0, illegal_op pulses for exactly 1 cycle; rst asserted mid-VEC_WAIT -> all outputs 0 on the next cycle.
